// File: rtl/conv_sched_pkg.sv
// Shared types and elaboration-time helpers for the convolution scheduler.
//   state_e  : scheduler FSM states
//   out_dim  : valid output extent of a map edge for a given kernel edge
//   addr_w   : address width needed to index a memory of a given depth
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WAIT_RES,
    WRITE,
    DONE
  } state_e;

  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

  // A depth of 1 still gets a 1-bit address so no port collapses to zero width.
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window / position counters for the convolution scheduler.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr           zero all counters (pass start or abort)
//   tap_step      advance kx/ky by one tap (kx fastest)
//   pos_step      advance col/row by one output position (col fastest)
//   w_rd_addr     ky*KERNEL_SIZE + kx
//   d_rd_addr     (row+ky)*IMG_W + (col+kx)
//   out_wr_addr   row*OUT_W + col
//   last_tap      kx and ky both at their final value
//   last_pos      row and col both at their final value
module conv_addr_gen
  import conv_sched_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8
) (
  input  logic                                                                    clk,
  input  logic                                                                    rst,
  input  logic                                                                    clr,
  input  logic                                                                    tap_step,
  input  logic                                                                    pos_step,
  output logic [addr_w(KERNEL_SIZE*KERNEL_SIZE)-1:0]                              w_rd_addr,
  output logic [addr_w(IMG_W*IMG_H)-1:0]                                          d_rd_addr,
  output logic [addr_w(out_dim(IMG_W,KERNEL_SIZE)*out_dim(IMG_H,KERNEL_SIZE))-1:0] out_wr_addr,
  output logic                                                                    last_tap,
  output logic                                                                    last_pos
);

  localparam int OUT_W = out_dim(IMG_W, KERNEL_SIZE);
  localparam int OUT_H = out_dim(IMG_H, KERNEL_SIZE);
  localparam int WA    = addr_w(KERNEL_SIZE * KERNEL_SIZE);
  localparam int DA    = addr_w(IMG_W * IMG_H);
  localparam int OA    = addr_w(OUT_W * OUT_H);
  localparam int KW    = addr_w(KERNEL_SIZE);
  localparam int CW    = addr_w(OUT_W);
  localparam int RW    = addr_w(OUT_H);

  logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    kx_d  = kx_q;
    ky_d  = ky_q;
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      kx_d  = '0;
      ky_d  = '0;
      col_d = '0;
      row_d = '0;
    end else begin
      // Both tap counters wrap back to 0 after the last tap, so the next
      // window starts from tap 0 without an explicit clear.
      if (tap_step) begin
        if (kx_q == KW'(KERNEL_SIZE - 1)) begin
          kx_d = '0;
          ky_d = (ky_q == KW'(KERNEL_SIZE - 1)) ? '0 : ky_q + KW'(1);
        end else begin
          kx_d = kx_q + KW'(1);
        end
      end
      if (pos_step) begin
        if (col_q == CW'(OUT_W - 1)) begin
          col_d = '0;
          row_d = (row_q == RW'(OUT_H - 1)) ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx_q  <= '0;
      ky_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      kx_q  <= kx_d;
      ky_q  <= ky_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign w_rd_addr   = WA'(ky_q) * WA'(KERNEL_SIZE) + WA'(kx_q);
  assign d_rd_addr   = (DA'(row_q) + DA'(ky_q)) * DA'(IMG_W) + DA'(col_q) + DA'(kx_q);
  assign out_wr_addr = OA'(row_q) * OA'(OUT_W) + OA'(col_q);
  assign last_tap    = (kx_q == KW'(KERNEL_SIZE - 1)) && (ky_q == KW'(KERNEL_SIZE - 1));
  assign last_pos    = (col_q == CW'(OUT_W - 1)) && (row_q == RW'(OUT_H - 1));

endmodule

// File: rtl/conv_scheduler.sv
// Convolution pass sequencer: walks every valid output position, fetches the
// KERNEL_SIZE x KERNEL_SIZE weight/data pairs into the MU, waits for the MU
// result and writes it to output memory.
// Optional feature macro: SCHED_TIMEOUT_EN (WAIT_RES cycle limit + error flag).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, abort                  pass control pulses
//   busy, done, error             pass status (error sticky until next start)
//   w_rd_*, d_rd_*                weight / data memory reads (1-cycle latency)
//   mu_*_valid, mu_weight/data    aligned pair stream to the MU
//   mu_flush                      clears MU accumulation on abort/timeout
//   mu_result, mu_result_valid    MU output
//   out_wr_*                      output memory write
module conv_scheduler
  import conv_sched_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic                                                                    clk,
  input  logic                                                                    rst,
  input  logic                                                                    start,
  input  logic                                                                    abort,
  output logic                                                                    busy,
  output logic                                                                    done,
  output logic                                                                    w_rd_en,
  output logic [addr_w(KERNEL_SIZE*KERNEL_SIZE)-1:0]                              w_rd_addr,
  input  logic [WIDTH-1:0]                                                        w_rd_data,
  output logic                                                                    d_rd_en,
  output logic [addr_w(IMG_W*IMG_H)-1:0]                                          d_rd_addr,
  input  logic [WIDTH-1:0]                                                        d_rd_data,
  output logic                                                                    mu_weight_valid,
  output logic                                                                    mu_data_valid,
  output logic [WIDTH-1:0]                                                        mu_weight,
  output logic [WIDTH-1:0]                                                        mu_data,
  output logic                                                                    mu_flush,
  input  logic [WIDTH-1:0]                                                        mu_result,
  input  logic                                                                    mu_result_valid,
  output logic                                                                    out_wr_en,
  output logic [addr_w(out_dim(IMG_W,KERNEL_SIZE)*out_dim(IMG_H,KERNEL_SIZE))-1:0] out_wr_addr,
  output logic [WIDTH-1:0]                                                        out_wr_data,
  output logic                                                                    error
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             pair_valid_q, pair_valid_d;
  logic             flush_q, flush_d;
  logic             clr, tap_step, pos_step, last_tap, last_pos;
  logic             active, abort_hit;

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = addr_w(TIMEOUT);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          error_q, error_d;
`endif

  conv_addr_gen #(
    .KERNEL_SIZE(KERNEL_SIZE),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .tap_step   (tap_step),
    .pos_step   (pos_step),
    .w_rd_addr  (w_rd_addr),
    .d_rd_addr  (d_rd_addr),
    .out_wr_addr(out_wr_addr),
    .last_tap   (last_tap),
    .last_pos   (last_pos)
  );

  // DONE is deliberately not "active": abort/start there are ignored so done
  // can never pulse twice for one pass.
  assign active    = (state_q == FETCH) || (state_q == DRAIN) ||
                     (state_q == WAIT_RES) || (state_q == WRITE);
  assign abort_hit = abort && active;

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    flush_d  = 1'b0;
    clr      = 1'b0;
    tap_step = 1'b0;
    pos_step = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    tcnt_d   = tcnt_q;
    error_d  = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          clr     = 1'b1;
`ifdef SCHED_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end
      end
      FETCH: begin
        tap_step = 1'b1;
        if (last_tap) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = WAIT_RES;
`ifdef SCHED_TIMEOUT_EN
        tcnt_d  = '0;
`endif
      end
      WAIT_RES: begin
        if (mu_result_valid) begin
          res_d   = mu_result;
          state_d = WRITE;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          flush_d = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      WRITE: begin
        pos_step = 1'b1;
        state_d  = last_pos ? DONE : FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything above, including a result arriving or a
    // timeout firing in the same cycle.
    if (abort_hit) begin
      state_d  = DONE;
      flush_d  = 1'b1;
      clr      = 1'b1;
      tap_step = 1'b0;
      pos_step = 1'b0;
      res_d    = res_q;
`ifdef SCHED_TIMEOUT_EN
      error_d  = error_q;
`endif
    end
  end

  // A read issued in the abort cycle must not reach the MU alongside the flush.
  assign pair_valid_d = (state_q == FETCH) && !abort_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      res_q        <= '0;
      pair_valid_q <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      res_q        <= res_d;
      pair_valid_q <= pair_valid_d;
      flush_q      <= flush_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q  <= '0;
      error_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      error_q <= error_d;
    end
  end
  assign error = error_q;
`else
  // Constant 0 for any legal TIMEOUT; the limit only matters with the counter.
  assign error = (TIMEOUT < 0);
`endif

  assign busy            = active;
  assign done            = (state_q == DONE);
  assign w_rd_en         = (state_q == FETCH);
  assign d_rd_en         = (state_q == FETCH);
  assign mu_weight_valid = pair_valid_q;
  assign mu_data_valid   = pair_valid_q;
  // Memory data is gated by the valid so stale read data never leaks out.
  assign mu_weight       = pair_valid_q ? w_rd_data : '0;
  assign mu_data         = pair_valid_q ? d_rd_data : '0;
  assign mu_flush        = flush_q;
  assign out_wr_en       = (state_q == WRITE);
  assign out_wr_data     = res_q;

endmodule
